// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_bridge
// Purpose  : UART (8N1) to 32-bit bus initiator. Receives framed commands
//            ('W' + 4 addr + 4 data bytes, or 'R' + 4 addr bytes, all
//            little-endian), issues one bus transaction per frame, and
//            replies with ACK (0x06), the 4 read-data bytes, or NAK (0x15)
//            for an unknown command byte.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            rx_pin / tx_pin   - serial receive / transmit, idle high
//            req_valid_o, req_ready_i, we_o, addr_o, data_o, sel_o
//                              - bus request channel
//            rsp_valid_i, data_i - bus response channel
//            busy_o            - high whenever the bridge is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_bridge #(
  parameter logic [15:0] BAUD_DIV    = 16'd868,        // clk cycles per bit (>= 4)
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000   // inter-byte idle limit
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] data_i,
  output logic        busy_o
);

  localparam logic [15:0] HALF_BIT  = BAUD_DIV >> 1;
  localparam logic [15:0] LAST_CYC  = BAUD_DIV - 16'd1;
  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK   = 8'h06;
  localparam logic [7:0]  RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_RSP  = 3'd4,
    S_TX   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_prev_d;
  logic        rx_busy_q, rx_busy_d;
  logic [15:0] rx_cnt_q,  rx_cnt_d;
  logic [3:0]  rx_bit_q,  rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] tout_q, tout_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        req_valid_q, req_valid_d;

  logic        tx_pin_q, tx_pin_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [2:0]  tx_left_q, tx_left_d;

  // Combinational event strobes
  logic        rx_done;    // good byte in rx_shift_d this cycle
  logic        rx_ferr;    // byte ended with a low stop bit
  logic        start_tx;
  logic        capture;
  logic        go_idle;

  // --------------------------------------------------------------------------
  // RX deserializer. rx_prev resets low so a line that is already low when
  // reset releases must first be seen high before a falling edge can count.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_prev_d  = rx_sync_q;
    rx_busy_d  = rx_busy_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_cnt_d  = 16'd0;
        rx_bit_d  = 4'd0;
      end
    end else begin
      rx_cnt_d = (rx_cnt_q == LAST_CYC) ? 16'd0 : rx_cnt_q + 16'd1;
      if (rx_cnt_q == HALF_BIT) begin
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          // Glitch rejection: start bit must still be low mid-bit
          if (rx_sync_q) rx_busy_d = 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          // Go idle at mid-stop so the next start edge is not missed
          rx_busy_d = 1'b0;
          rx_done   = rx_sync_q;
          rx_ferr   = !rx_sync_q;
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame / bus / TX control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tout_d      = tout_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_valid_d = req_valid_q;
    tx_pin_d    = tx_pin_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_data_d   = tx_data_q;
    tx_left_d   = tx_left_q;
    start_tx    = 1'b0;
    capture     = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          if (rx_shift_q == CMD_WRITE || rx_shift_q == CMD_READ) begin
            we_d       = (rx_shift_q == CMD_WRITE);
            state_d    = S_ADDR;
            byte_cnt_d = 2'd0;
            tout_d     = 32'd0;
          end else begin
            tx_data_d = {24'd0, RSP_NAK};
            tx_left_d = 3'd1;
            start_tx  = 1'b1;
          end
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_ferr) begin
          go_idle = 1'b1;
        end else if (rx_done) begin
          tout_d     = 32'd0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d = {rx_shift_q, addr_q[31:8]};
          else                   data_d = {rx_shift_q, data_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_ADDR && we_q) begin
              state_d = S_DATA;
            end else begin
              state_d     = S_REQ;
              req_valid_d = 1'b1;
            end
          end
        end else if (tout_q >= TIMEOUT_CYC - 32'd1) begin
          go_idle = 1'b1;
        end else begin
          tout_d = tout_q + 32'd1;
        end
      end

      S_REQ: begin
        if (req_ready_i) begin
          req_valid_d = 1'b0;
          // A response arriving with the accepting ready is taken directly
          if (rsp_valid_i) capture = 1'b1;
          else             state_d = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_valid_i) capture = 1'b1;
      end

      S_TX: begin
        if (tx_cnt_q == LAST_CYC) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 4'd9) begin
            if (tx_left_q > 3'd1) begin
              // Next byte starts immediately: no idle gap between bytes
              tx_left_d = tx_left_q - 3'd1;
              tx_data_d = {8'd0, tx_data_q[31:8]};
              tx_bit_d  = 4'd0;
              tx_pin_d  = 1'b0;
            end else begin
              tx_left_d = 3'd0;
              tx_pin_d  = 1'b1;
              go_idle   = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_pin_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_data_q[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end

      default: go_idle = 1'b1;
    endcase

    if (capture) begin
      tx_data_d = we_q ? {24'd0, RSP_ACK} : data_i;
      tx_left_d = we_q ? 3'd1 : 3'd4;
      start_tx  = 1'b1;
    end

    if (start_tx) begin
      state_d  = S_TX;
      tx_pin_d = 1'b0;
      tx_cnt_d = 16'd0;
      tx_bit_d = 4'd0;
    end

    if (go_idle) begin
      state_d     = S_IDLE;
      byte_cnt_d  = 2'd0;
      tout_d      = 32'd0;
      we_d        = 1'b0;
      addr_d      = 32'd0;
      data_d      = 32'd0;
      req_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= 8'd0;
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      tout_q      <= 32'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      req_valid_q <= 1'b0;
      tx_pin_q    <= 1'b1;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 4'd0;
      tx_data_q   <= 32'd0;
      tx_left_q   <= 3'd0;
    end else begin
      rx_meta_q   <= rx_pin;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_prev_d;
      rx_busy_q   <= rx_busy_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tout_q      <= tout_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      req_valid_q <= req_valid_d;
      tx_pin_q    <= tx_pin_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_data_q   <= tx_data_d;
      tx_left_q   <= tx_left_d;
    end
  end

  assign tx_pin      = tx_pin_q;
  assign req_valid_o = req_valid_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign sel_o       = 4'hF;
  assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_bridge
// Purpose  : Self-checking bench for uart_bus_bridge. Stimulus sends frames
//            and pushes the expected bus transactions and reply bytes into
//            queues; independent bus and TX monitors pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_bridge;

  localparam int BD = 16;
  localparam int TO = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] data_i = 32'd0;
  logic        tx_pin, req_valid_o, we_o, busy_o;
  logic [31:0] addr_o, data_o;
  logic [3:0]  sel_o;

  uart_bus_bridge #(.BAUD_DIV(16'(BD)), .TIMEOUT_CYC(32'(TO))) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .tx_pin(tx_pin),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o),
    .rsp_valid_i(rsp_valid_i), .data_i(data_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_exp_t;
  typedef struct { int stall; int delay; logic [31:0] rdata; } bus_plan_t;
  typedef struct { logic [7:0] b; bit first; } tx_exp_t;

  bus_exp_t  exp_bus[$];
  bus_plan_t plan_q[$];
  tx_exp_t   exp_tx[$];
  bit        tx_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- serial host driver ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_pin = stop;
    repeat (BD) @(negedge clk);
    rx_pin = 1'b1;
    if (!stop) repeat (BD) @(negedge clk);
  endtask

  // ---------------- reference model: frame -> expectations ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int stall, input int delay);
    bus_exp_t e; bus_plan_t p; tx_exp_t t;
    e.we = 1'b1; e.addr = a; e.data = d; exp_bus.push_back(e);
    p.stall = stall; p.delay = delay; p.rdata = $urandom; plan_q.push_back(p);
    t.b = 8'h06; t.first = 1'b1; exp_tx.push_back(t);
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall, input int delay,
                         input logic [31:0] rd, input bit expect_tx);
    bus_exp_t e; bus_plan_t p; tx_exp_t t;
    e.we = 1'b0; e.addr = a; e.data = 32'd0; exp_bus.push_back(e);
    p.stall = stall; p.delay = delay; p.rdata = rd; plan_q.push_back(p);
    if (expect_tx) begin
      for (int i = 0; i < 4; i++) begin
        t.b = rd[8*i +: 8]; t.first = (i == 0); exp_tx.push_back(t);
      end
    end
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy_o || tx_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++; bad++;
      $display("FAIL %s_done: still busy after %0d cycles, expected idle", name, n);
      exp_tx.delete(); exp_bus.delete(); plan_q.delete();
    end
    repeat (20) @(negedge clk);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_txidle"}, tx_pin, 1);
  endtask

  // ---------------- bus responder + request monitor ----------------
  initial begin
    int phase; int cnt; bus_plan_t cur; bus_exp_t e;
    phase = 0; cnt = 0;
    forever begin
      @(negedge clk);
      rsp_valid_i = 1'b0;
      if (!rst_n) begin
        phase = 0; req_ready_i = 1'b0;
      end else begin
        if (phase == 0 && req_valid_o) begin
          if (exp_bus.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_req: unexpected request addr=%h we=%b, expected none", addr_o, we_o);
          end
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          else begin cur.stall = 0; cur.delay = 1; cur.rdata = 32'h0; end
          cnt = cur.stall; phase = 1;
        end
        if (phase == 1) begin
          if (cnt > 0) begin
            cnt--; req_ready_i = 1'b0;
            if (exp_bus.size() != 0) begin
              check("stall_valid", req_valid_o, 1);
              check("stall_addr", addr_o, exp_bus[0].addr);
              check("stall_we", we_o, exp_bus[0].we);
            end
          end else begin
            if (exp_bus.size() != 0) begin
              e = exp_bus.pop_front();
              check("req_valid", req_valid_o, 1);
              check("req_we", we_o, e.we);
              check("req_addr", addr_o, e.addr);
              check("req_data", data_o, e.data);
              check("req_sel", sel_o, 4'hF);
            end
            req_ready_i = 1'b1;
            if (cur.delay == 0) begin
              rsp_valid_i = 1'b1; data_i = cur.rdata; phase = 3;
            end else begin
              cnt = cur.delay; phase = 2;
            end
          end
        end else if (phase == 2) begin
          if (req_ready_i) check("req_drop", req_valid_o, 0);
          req_ready_i = 1'b0;
          cnt--;
          if (cnt == 0) begin rsp_valid_i = 1'b1; data_i = cur.rdata; phase = 3; end
        end else if (phase == 3) begin
          if (req_ready_i) check("req_drop", req_valid_o, 0);
          req_ready_i = 1'b0;
          phase = 0;
        end
      end
    end
  end

  // ---------------- TX line monitor ----------------
  initial begin
    logic prev; logic [9:0] bits; bit ab; int st; int last_st; tx_exp_t t;
    prev = 1'b1; last_st = -100000;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !tx_pin) begin
        tx_active = 1'b1; ab = 1'b0; st = cyc; bits = '0;
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < ((i == 0) ? BD/2 : BD); k++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
          end
          bits[i] = tx_pin;
        end
        tx_active = 1'b0;
        if (!ab) begin
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_byte: unexpected byte %h, expected none", bits[8:1]);
          end else begin
            t = exp_tx.pop_front();
            check("tx_frame", {54'd0, bits}, {54'd0, 1'b1, t.b, 1'b0});
            if (!t.first) check("tx_gap", st - last_st, 10*BD);
          end
          last_st = st;
        end
      end
      prev = tx_pin;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_pin, 1);
    check("rst_req", req_valid_o, 0);
    check("rst_we", we_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_sel", sel_o, 4'hF);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Directed write
    do_write(32'h8000_1000, 32'hDEAD_BEEF, 0, 1);
    wait_idle("write");

    // Read with 5-cycle stall, response 3 cycles after accept
    do_read(32'h2000_0004, 5, 3, 32'h1234_5678, 1'b1);
    wait_idle("read_stall");

    // Unknown command -> NAK only
    begin
      tx_exp_t t; t.b = 8'h15; t.first = 1'b1; exp_tx.push_back(t);
      send_byte(8'h41, 1'b1);
      wait_idle("nak");
    end

    // Partial frame then silence -> timeout, no response
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    check("partial_busy", busy_o, 1);
    repeat (TO + 200) @(negedge clk);
    check("timeout_busy", busy_o, 0);
    check("timeout_addr", addr_o, 0);
    do_read(32'h2000_0004, 1, 0, 32'hCAFE_F00D, 1'b1);
    wait_idle("after_timeout");

    // Framing error on second address byte -> silent discard
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_busy", busy_o, 0);
    do_write(32'h0000_0040, 32'h0BAD_F00D, 2, 2);
    wait_idle("after_ferr");

    // Reset during reply transmission, line held low across release
    do_read(32'h0000_1234, 0, 1, 32'hA5A5_5A5A, 1'b0);
    n = 0;
    while (tx_pin && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL rst_tx_start: no start bit after %0d cycles, expected one", n);
    end
    repeat (3*BD) @(negedge clk);
    rx_pin = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_tx", tx_pin, 1);
    check("midrst_req", req_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_addr", addr_o, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3*BD) @(negedge clk);
    check("lowrel_busy", busy_o, 0);
    do_read(32'h0000_0010, 0, 2, 32'h0102_0304, 1'b1);
    wait_idle("after_rst");

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 4));
      else
        do_read($urandom, $urandom_range(0, 6), $urandom_range(0, 4), $urandom, 1'b1);
      wait_idle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
